// File: rtl/alu_dispatcher.sv
// Registered command front-end for the base-selecting ALU router: one command in flight, response handshake out.
// Optional WAIT-state abort is compiled in with `define ALU_DISPATCH_TIMEOUT_EN.
module alu_dispatcher #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_operation,
  input  logic [31:0]      cmd_operand_a,
  input  logic [31:0]      cmd_operand_b,
  input  logic [1:0]       cmd_base,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_status,
  output logic [3:0]       alu_operation,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [1:0]       alu_base_select,
  input  logic [31:0]      alu_result,
  input  logic             alu_done,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADBASE = 2'b01;

  state_t             state_q, state_d;
  logic [3:0]         alu_operation_q, alu_operation_d;
  logic [31:0]        alu_operand_a_q, alu_operand_a_d;
  logic [31:0]        alu_operand_b_q, alu_operand_b_d;
  logic [1:0]         alu_base_q, alu_base_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [1:0]         rsp_status_q, rsp_status_d;
  logic [15:0]        op_count_q, op_count_d;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic [15:0]        timer_q, timer_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign cmd_ready       = (state_q == S_IDLE) && !reset;
  assign busy            = (state_q != S_IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_tag         = rsp_tag_q;
  assign rsp_status      = rsp_status_q;
  assign alu_operation   = alu_operation_q;
  assign alu_operand_a   = alu_operand_a_q;
  assign alu_operand_b   = alu_operand_b_q;
  assign alu_base_select = alu_base_q;
  assign op_count        = op_count_q;

  always_comb begin
    state_d         = state_q;
    alu_operation_d = alu_operation_q;
    alu_operand_a_d = alu_operand_a_q;
    alu_operand_b_d = alu_operand_b_q;
    alu_base_d      = alu_base_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_result_d    = rsp_result_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_status_d    = rsp_status_q;
    op_count_d      = op_count_q;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    timer_d         = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rsp_tag_d = cmd_tag;
          // An illegal base never reaches the router, so its inputs keep the last legal command.
          if (cmd_base == 2'd3) begin
            rsp_result_d = 32'd0;
            rsp_status_d = ST_BADBASE;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else begin
            alu_operation_d = cmd_operation;
            alu_operand_a_d = cmd_operand_a;
            alu_operand_b_d = cmd_operand_b;
            alu_base_d      = cmd_base;
            state_d         = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        timer_d = 16'd0;
`endif
      end
      S_WAIT: begin
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_status_d = ST_OK;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d = 32'hFFFF_FFFF;
          rsp_status_d = 2'b10;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (rsp_status_q == ST_OK && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      alu_operation_q <= 4'd0;
      alu_operand_a_q <= 32'd0;
      alu_operand_b_q <= 32'd0;
      alu_base_q      <= 2'd0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= 32'd0;
      rsp_tag_q       <= '0;
      rsp_status_q    <= 2'b00;
      op_count_q      <= 16'd0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      timer_q         <= 16'd0;
`endif
    end else begin
      state_q         <= state_d;
      alu_operation_q <= alu_operation_d;
      alu_operand_a_q <= alu_operand_a_d;
      alu_operand_b_q <= alu_operand_b_d;
      alu_base_q      <= alu_base_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q    <= rsp_result_d;
      rsp_tag_q       <= rsp_tag_d;
      rsp_status_q    <= rsp_status_d;
      op_count_q      <= op_count_d;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      timer_q         <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_dispatcher.sv
// Directed + randomized bench for alu_dispatcher (default build, timeout feature not compiled in).
// Expected responses come from a behavioural model: bad base -> (0, 01), otherwise router result a+b with status 00.
module tb_alu_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_operation;
  logic [31:0] cmd_operand_a;
  logic [31:0] cmd_operand_b;
  logic [1:0]  cmd_base;
  logic [3:0]  cmd_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [1:0]  rsp_status;
  logic [3:0]  alu_operation;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [1:0]  alu_base_select;
  logic [31:0] alu_result;
  logic        alu_done;
  logic        busy;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model of what the router inputs should currently hold, and of the op counter.
  logic [3:0]  shOp;
  logic [31:0] shA, shB;
  logic [1:0]  shBase;
  logic [15:0] opCountModel;

  alu_dispatcher #(.TIMEOUT_CYCLES(64), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_operation(cmd_operation), .cmd_operand_a(cmd_operand_a),
    .cmd_operand_b(cmd_operand_b), .cmd_base(cmd_base), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_status(rsp_status),
    .alu_operation(alu_operation), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_base_select(alu_base_select),
    .alu_result(alu_result), .alu_done(alu_done),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic checkAluHeld(input string name);
    checkOutput({name, "_alu_op"}, alu_operation, shOp);
    checkOutput({name, "_alu_a"}, alu_operand_a, shA);
    checkOutput({name, "_alu_b"}, alu_operand_b, shB);
    checkOutput({name, "_alu_base"}, alu_base_select, shBase);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({name, "_rsp_result"}, rsp_result, 0);
    checkOutput({name, "_rsp_tag"}, rsp_tag, 0);
    checkOutput({name, "_rsp_status"}, rsp_status, 0);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_op_count"}, op_count, 0);
    checkAluHeld(name);
  endtask

  // One full command: accept, optional router wait of d cycles, response held for hold cycles, handshake.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] base, input logic [3:0] tag, input int d,
                               input int hold, input bit issueDone, output int acceptCyc);
    int n;
    logic [31:0] expRes;
    logic [1:0]  expSt;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("cmd_ready_before_accept", cmd_ready, 1);
    cmd_operation = op;
    cmd_operand_a = a;
    cmd_operand_b = b;
    cmd_base      = base;
    cmd_tag       = tag;
    cmd_valid     = 1'b1;
    tick();
    acceptCyc     = cyc;
    cmd_valid     = 1'b0;
    cmd_operation = 4'($urandom);
    cmd_operand_a = $urandom;
    cmd_operand_b = $urandom;
    cmd_base      = 2'($urandom);
    cmd_tag       = 4'($urandom);
    if (base == 2'd3) begin
      expRes = 32'd0;
      expSt  = 2'b01;
    end else begin
      shOp = op; shA = a; shB = b; shBase = base;
      checkAluHeld("issue");
      checkOutput("issue_busy", busy, 1);
      checkOutput("issue_cmd_ready", cmd_ready, 0);
      checkOutput("issue_rsp_valid", rsp_valid, 0);
      alu_done   = issueDone;
      alu_result = $urandom;
      tick();
      alu_done = 1'b0;
      for (int i = 0; i < d; i++) begin
        checkOutput("wait_rsp_valid", rsp_valid, 0);
        tick();
      end
      alu_done   = 1'b1;
      alu_result = a + b;
      tick();
      alu_done   = 1'b0;
      alu_result = $urandom;
      expRes = a + b;
      expSt  = 2'b00;
    end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_result", rsp_result, expRes);
    checkOutput("rsp_tag", rsp_tag, tag);
    checkOutput("rsp_status", rsp_status, expSt);
    checkOutput("rsp_latency", cyc - acceptCyc, (base == 2'd3) ? 0 : 2 + d);
    for (int i = 0; i < hold; i++) begin
      alu_done   = 1'($urandom);
      alu_result = $urandom;
      tick();
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_result", rsp_result, expRes);
      checkOutput("hold_rsp_tag", rsp_tag, tag);
      checkOutput("hold_rsp_status", rsp_status, expSt);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
    end
    alu_done  = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    if (expSt == 2'b00 && opCountModel != 16'hFFFF) opCountModel++;
    checkOutput("post_rsp_valid", rsp_valid, 0);
    checkOutput("post_cmd_ready", cmd_ready, 1);
    checkOutput("post_op_count", op_count, opCountModel);
    checkAluHeld("post");
  endtask

  initial begin
    int acc [3];
    int tmp;
    int n;
    logic [1:0] rbase;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_operation = '0; cmd_operand_a = '0; cmd_operand_b = '0;
    cmd_base = '0; cmd_tag = '0; rsp_ready = 1'b0; alu_result = '0; alu_done = 1'b0;
    shOp = '0; shA = '0; shB = '0; shBase = '0; opCountModel = '0;
    tick();
    tick();
    checkResetValues("reset");
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    tick();
    checkOutput("after_reset_cmd_ready", cmd_ready, 1);

    $display("[TB] basic add and bad base");
    applyStimulus(4'd0, 32'd5, 32'd7, 2'd0, 4'd3, 0, 0, 1'b0, tmp);
    applyStimulus(4'd2, 32'd11, 32'd13, 2'd3, 4'd9, 0, 0, 1'b0, tmp);

    $display("[TB] response backpressure");
    applyStimulus(4'd5, 32'h1234, 32'h10, 2'd1, 4'd6, 2, 10, 1'b1, tmp);

    $display("[TB] reset while waiting on the router");
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    cmd_operation = 4'd7; cmd_operand_a = 32'd100; cmd_operand_b = 32'd200;
    cmd_base = 2'd2; cmd_tag = 4'd4; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    shOp = '0; shA = '0; shB = '0; shBase = '0; opCountModel = '0;
    checkResetValues("async_reset");
    checkOutput("async_reset_cmd_ready", cmd_ready, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_done = 1'b1;
      tick();
      checkOutput("no_rsp_after_reset", rsp_valid, 0);
      checkOutput("idle_cmd_ready", cmd_ready, 1);
    end
    alu_done = 1'b0;
    applyStimulus(4'd1, 32'd40, 32'd2, 2'd2, 4'd8, 1, 0, 1'b0, tmp);

    $display("[TB] back-to-back commands");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'(i + 3), $urandom, $urandom, 2'(i), 4'(i + 1), 0, 0, 1'b0, acc[i]);
    end
    checkOutput("b2b_period_01", acc[1] - acc[0], 4);
    checkOutput("b2b_period_12", acc[2] - acc[1], 4);

    $display("[TB] randomized commands");
    for (int i = 0; i < 25; i++) begin
      rbase = 2'($urandom_range(0, 3));
      applyStimulus(4'($urandom), $urandom, $urandom, rbase, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    1'($urandom), tmp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_dispatcher.md
# alu_dispatcher

Command front-end for the base-selecting ALU router. Accepts one arithmetic command per valid/ready handshake and registers it onto the router's operation, operand and base-select inputs. It holds those inputs stable until the router signals done, then returns the captured result with a tag and status over a response handshake. It sits directly upstream of the router, isolating the rest of the design from ALU latency and from invalid base codes.

## Interface
- TIMEOUT_CYCLES, 64: cycles spent in WAIT without alu_done before the dispatcher aborts (only with the timeout feature compiled in); legal range 2..65535.
- TAG_W, 4: width of the command/response tag.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  dispatcher can accept a command.
- cmd_operation  in  4  ALU opcode, passed through unmodified.
- cmd_operand_a  in  32  operand A.
- cmd_operand_b  in  32  operand B.
- cmd_base  in  2  0=base2, 1=base10, 2=base12, 3=illegal.
- cmd_tag  in  TAG_W  returned unchanged on the response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured ALU result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_status  out  2  00=ok, 01=bad base, 10=timeout.
- alu_operation  out  4  to router operation.
- alu_operand_a  out  32  to router operand_a.
- alu_operand_b  out  32  to router operand_b.
- alu_base_select  out  2  to router base_select.
- alu_result  in  32  from router result.
- alu_done  in  1  from router done.
- busy  out  1  high in every state except IDLE.
- op_count  out  16  count of status-00 responses handed off; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - cmd_ready = (state==IDLE) && !reset.
  - On cmd_valid && cmd_ready, register operation, operands, base and tag.
  - If cmd_base==3, go to RESP with status 01 and result 0. alu_* outputs are not updated.
  - Otherwise update alu_* outputs and go to ISSUE.
- **ISSUE**: one cycle. The router sees the new inputs. alu_done is ignored in this cycle. Always go to WAIT.
- **WAIT**
  - Timeout counter cleared on entry.
  - On alu_done=1, capture alu_result into rsp_result, set status 00, go to RESP.
  - Otherwise increment the counter.
- **RESP**
  - rsp_valid=1. rsp_result, rsp_tag and rsp_status are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. If status==00, op_count increments with saturation.
- alu_* outputs hold their last issued values after completion. They change only at the next legal accept.
- alu_done outside WAIT has no effect.
- Asynchronous reset at any point aborts the operation in flight. No response is produced for it.

## Timing
- Reset values:
  - state IDLE, busy 0, cmd_ready 0 while reset is asserted.
  - rsp_valid 0, rsp_result 0, rsp_tag 0, rsp_status 00.
  - alu_operation 0, alu_operand_a 0, alu_operand_b 0, alu_base_select 0.
  - op_count 0, timeout counter 0.
- cmd_ready is high in the first cycle after reset deasserts.
- Accept at edge T:
  - alu_* valid from T+1 (ISSUE).
  - WAIT from T+2.
  - alu_done sampled high at edge W≥T+2 gives rsp_valid from W+1.
  - Minimum accept-to-rsp_valid latency is 3 cycles.
- Bad base: rsp_valid from T+1.
- After the response handshake at edge R, cmd_ready is high from R+1. There is no same-cycle accept.
- Minimum sustained period is 4 cycles per legal command.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

## Configuration
- Macro: ALU_DISPATCH_TIMEOUT_EN.
- Defined:
  - WAIT aborts once the counter reaches TIMEOUT_CYCLES without alu_done, going to RESP with status 10, result 0xFFFFFFFF and the original tag.
  - If alu_done arrives in the same cycle the limit is reached, done wins and status is 00.
- Undefined:
  - No counter logic. WAIT persists until alu_done.
  - Status 10 is never produced. TIMEOUT_CYCLES is ignored.

## Test plan
- After reset: all outputs at their reset values and cmd_ready=1. Send op=0, A=5, B=7, base=0, tag=3. Router model raises done at T+2 with result 12 → alu_* driven at T+1, rsp_valid at T+3 with result 12, tag 3, status 00, op_count=1.
- cmd_base=3, tag=9 → rsp_valid at T+1 with status 01, result 0, tag 9. alu_* unchanged, op_count unchanged.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_* stable and cmd_ready=0 throughout. Release it → cmd_ready=1 the following cycle.
- With the macro defined and TIMEOUT_CYCLES=4, done never asserted → status 10 and result 0xFFFFFFFF. In a second run, done coincides with the 4th WAIT cycle → status 00.
- Assert reset for one cycle while in WAIT, with base=2 issued → all outputs return to reset values immediately, no response ever appears, and the next command completes normally.
- Back-to-back commands with rsp_ready=1: base 0, 1, 2 with tags 1, 2, 3 → responses in order 1, 2, 3, one per 4 cycles, and alu_base_select steps 0→1→2.
